// File: rtl/bird_sprite_engine.sv
// Multi-bird sprite renderer: per frame tick, erases, moves and redraws each bird, one pixel per cycle.
// Per bird: 1 check cycle, 13 erase cycles if drawn, 1 move + 13 draw cycles if enabled; one DONE cycle per frame.
module bird_sprite_engine #(
   parameter int         N_BIRDS      = 6,
   parameter int         STEP         = 1,
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter int         X_START      = 5,
   parameter int         X_SPACING    = 24,
   parameter logic [2:0] DRAW_COLOUR  = 3'b111,
   parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [N_BIRDS-1:0]     bird_en,
   input  logic [7*N_BIRDS-1:0]   bird_y,
   output logic [7:0]             x_out,
   output logic [6:0]             y_out,
   output logic [2:0]             colour,
   output logic                   plot,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   localparam int            BW       = (N_BIRDS > 1) ? $clog2(N_BIRDS) : 1;
   localparam logic [BW-1:0] LAST     = BW'(N_BIRDS - 1);
   localparam logic [3:0]    LAST_PIX = 4'd12;
   localparam logic [8:0]    SW9      = 9'(SCREEN_W);
   localparam logic [7:0]    SH8      = 8'(SCREEN_H);

   typedef enum logic [2:0] {IDLE, CHECK, ERASE, MOVE, DRAW, DONE} state_t;

   state_t             state;
   logic [BW-1:0]      b;
   logic [3:0]         p;
   logic [7:0]         x_pos [N_BIRDS];
   logic [6:0]         y_pos [N_BIRDS];
   logic [N_BIRDS-1:0] drawn;
   logic [N_BIRDS-1:0] en_snap;
   logic               pending;

   // Sprite offsets as modular increments: negative offsets are two's complement.
   function automatic logic [7:0] spr_dx(input logic [3:0] idx);
      case (idx)
         4'd2:                 spr_dx = 8'd255;
         4'd3:                 spr_dx = 8'd254;
         4'd4, 4'd7, 4'd8:     spr_dx = 8'd253;
         4'd5, 4'd9, 4'd10:    spr_dx = 8'd252;
         4'd6, 4'd11, 4'd12:   spr_dx = 8'd251;
         default:              spr_dx = 8'd0;
      endcase
   endfunction

   function automatic logic [6:0] spr_dy(input logic [3:0] idx);
      case (idx)
         4'd1, 4'd7: spr_dy = 7'd1;
         4'd8:       spr_dy = 7'd127;
         4'd9:       spr_dy = 7'd2;
         4'd10:      spr_dy = 7'd126;
         4'd11:      spr_dy = 7'd3;
         4'd12:      spr_dy = 7'd125;
         default:    spr_dy = 7'd0;
      endcase
   endfunction

   logic [8:0] x_sum;
   logic [7:0] x_next;
   logic [6:0] y_next;
   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [3:0] pix_idx;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic       pix_vis;

   // Pixel to be presented in the next cycle; MOVE draws from the freshly advanced position.
   always_comb begin
      x_sum   = {1'b0, x_pos[b]} + 9'(STEP);
      x_next  = (x_sum >= SW9) ? 8'(x_sum - SW9) : x_sum[7:0];
      y_next  = bird_y[7*int'(b) +: 7];
      base_x  = (state == MOVE) ? x_next : x_pos[b];
      base_y  = (state == MOVE) ? y_next : y_pos[b];
      pix_idx = (state == ERASE || state == DRAW) ? p + 4'd1 : 4'd0;
      pix_x   = base_x + spr_dx(pix_idx);
      pix_y   = base_y + spr_dy(pix_idx);
      pix_vis = ({1'b0, pix_x} < SW9) && ({1'b0, pix_y} < SH8);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         b          <= '0;
         p          <= '0;
         for (int i = 0; i < N_BIRDS; i++) begin
            x_pos[i] <= 8'((X_START + i*X_SPACING) % SCREEN_W);
            y_pos[i] <= '0;
         end
         drawn      <= '0;
         en_snap    <= '0;
         pending    <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         plot       <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_tick || pending) begin
                  state   <= CHECK;
                  b       <= '0;
                  en_snap <= bird_en;
                  pending <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            CHECK: begin
               if (drawn[b]) begin
                  state  <= ERASE;
                  p      <= '0;
                  x_out  <= pix_x;
                  y_out  <= pix_y;
                  colour <= ERASE_COLOUR;
                  plot   <= pix_vis;
               end else if (en_snap[b]) begin
                  state <= MOVE;
               end else if (b == LAST) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else begin
                  b     <= b + 1'b1;
                  state <= CHECK;
               end
            end
            ERASE: begin
               if (p == LAST_PIX) begin
                  drawn[b] <= 1'b0;
                  if (en_snap[b]) begin
                     state <= MOVE;
                  end else if (b == LAST) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     b     <= b + 1'b1;
                     state <= CHECK;
                  end
               end else begin
                  p      <= p + 4'd1;
                  x_out  <= pix_x;
                  y_out  <= pix_y;
                  colour <= ERASE_COLOUR;
                  plot   <= pix_vis;
               end
            end
            MOVE: begin
               x_pos[b] <= x_next;
               y_pos[b] <= y_next;
               state    <= DRAW;
               p        <= '0;
               x_out    <= pix_x;
               y_out    <= pix_y;
               colour   <= DRAW_COLOUR;
               plot     <= pix_vis;
            end
            DRAW: begin
               if (p == LAST_PIX) begin
                  drawn[b] <= 1'b1;
                  if (b == LAST) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     b     <= b + 1'b1;
                     state <= CHECK;
                  end
               end else begin
                  p      <= p + 4'd1;
                  x_out  <= pix_x;
                  y_out  <= pix_y;
                  colour <= DRAW_COLOUR;
                  plot   <= pix_vis;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // A tick seen in any busy state, DONE included, queues exactly one more frame.
         if (frame_tick && state != IDLE) begin
            pending <= 1'b1;
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bird_sprite_engine.sv
// Directed plus randomized frames for bird_sprite_engine, checked cycle by cycle against a frame-level model.
module tb_bird_sprite_engine;

   localparam int NB = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic            frame_tick;
   logic [NB-1:0]   bird_en;
   logic [7*NB-1:0] bird_y;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   logic [2:0]      colour;
   logic            plot;
   logic            busy;
   logic            frame_done;
   logic            overrun;

   bird_sprite_engine #(.N_BIRDS(NB)) dut (
      .clock      (clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .bird_en    (bird_en),
      .bird_y     (bird_y),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit pix;
      bit plot;
      int x;
      int y;
      int col;
      bit done;
   } exp_t;

   exp_t q[$];
   int   mx [NB];
   int   my [NB];
   bit   mdrawn [NB];
   bit   mpending;
   bit   moverrun;
   int   DX [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
   int   DY [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mx[i]     = (5 + 24*i) % 160;
         my[i]     = 0;
         mdrawn[i] = 0;
      end
      mpending = 0;
      moverrun = 0;
   endtask

   task automatic push_ctl(input bit done);
      exp_t e;
      e = '{pix: 0, plot: 0, x: 0, y: 0, col: 0, done: done};
      q.push_back(e);
   endtask

   task automatic push_sprite(input int bi, input int col);
      exp_t e;
      for (int k = 0; k < 13; k++) begin
         e.pix  = 1;
         e.x    = (mx[bi] + DX[k]) & 255;
         e.y    = (my[bi] + DY[k]) & 127;
         e.plot = (e.x < 160) && (e.y < 120);
         e.col  = col;
         e.done = 0;
         q.push_back(e);
      end
   endtask

   // Expected per-cycle output stream of one frame, from the erase/move/draw rules.
   task automatic build(input logic [NB-1:0] en, input logic [7*NB-1:0] ys);
      q.delete();
      for (int bi = 0; bi < NB; bi++) begin
         push_ctl(0);
         if (mdrawn[bi]) begin
            push_sprite(bi, 0);
            mdrawn[bi] = 0;
         end
         if (en[bi]) begin
            push_ctl(0);
            mx[bi] = mx[bi] + 1;
            if (mx[bi] >= 160) mx[bi] = mx[bi] - 160;
            my[bi] = int'(ys[7*bi +: 7]);
            push_sprite(bi, 7);
            mdrawn[bi] = 1;
         end
      end
      push_ctl(1);
   endtask

   task automatic idle_check();
      chk("idle_busy", busy, 0);
      chk("idle_plot", plot, 0);
      chk("idle_done", frame_done, 0);
      chk("idle_overrun", overrun, moverrun);
   endtask

   task automatic run_frame(input bit use_tick, input int extra1, input int extra2, input int abort_at);
      build(bird_en, bird_y);
      mpending   = 0;
      frame_tick = use_tick;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      bird_en    = NB'($urandom);
      for (int k = 0; k < q.size(); k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            model_reset();
            chk("abort_plot", plot, 0);
            chk("abort_busy", busy, 0);
            chk("abort_overrun", overrun, 0);
            return;
         end
         chk("busy", busy, 1);
         chk("plot", plot, q[k].plot);
         chk("frame_done", frame_done, q[k].done);
         if (q[k].pix) begin
            chk("x_out", x_out, q[k].x);
            chk("y_out", y_out, q[k].y);
            chk("colour", colour, q[k].col);
         end
         if (k == extra1 || k == extra2) begin
            frame_tick = 1'b1;
            mpending   = 1;
            moverrun   = 1;
         end
         @(posedge clock); #1;
         frame_tick = 1'b0;
      end
      idle_check();
   endtask

   initial begin
      int ext;
      reset      = 1'b1;
      frame_tick = 1'b0;
      bird_en    = '0;
      bird_y     = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_colour", colour, 0);
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      idle_check();

      // First frame draws only, second erases then redraws.
      bird_en = 2'b11;
      bird_y  = {7'd40, 7'd20};
      run_frame(1, -1, -1, -1);
      bird_en = 2'b11;
      run_frame(1, -1, -1, -1);

      // Bird 1 disabled: one erase-only frame, then a single check cycle.
      bird_en = 2'b01;
      run_frame(1, -1, -1, -1);
      bird_en = 2'b01;
      run_frame(1, -1, -1, -1);

      // Vertical clipping at both screen edges.
      bird_en = 2'b11;
      bird_y  = {7'd119, 7'd0};
      run_frame(1, -1, -1, -1);
      bird_en = 2'b11;
      bird_y  = {7'd0, 7'd119};
      run_frame(1, -1, -1, -1);

      // Tick mid-frame and on DONE: one extra frame only, overrun sticky.
      bird_en = 2'b11;
      bird_y  = {7'd60, 7'd30};
      run_frame(1, 10, 56, -1);
      bird_en = 2'b10;
      run_frame(0, -1, -1, -1);
      repeat (3) begin
         @(posedge clock); #1;
         idle_check();
      end

      // Reset during the first bird's erase.
      bird_en = 2'b11;
      run_frame(1, -1, -1, 5);
      @(posedge clock); #1;
      idle_check();
      bird_en = 2'b11;
      run_frame(1, -1, -1, -1);

      // Randomized frames, long enough for both birds to wrap past x=159.
      for (int f = 0; f < 260; f++) begin
         bird_en[0] = ($urandom_range(0, 7) != 0);
         bird_en[1] = ($urandom_range(0, 3) != 0);
         bird_y     = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
         ext        = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : -1;
         run_frame(!mpending, ext, -1, -1);
      end
      if (mpending) begin
         bird_en = 2'b00;
         run_frame(0, -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
